pc_sequencer: RTL

- Owns the program counter and sequences next-PC selection for the 5-stage pipeline's fetch stage.
- Arbitrates redirect sources with fixed priority: JR > J/JAL > BEQ/BNE > PC+4.
- Applies hazard-unit stalls and the post-reset boot delay.
- Generates the IF/ID flush window after each taken redirect.

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: redirect/stall/halt requests in, PC and status out.
// PC_SEQ_STATS_EN adds the redirect and stall statistics outputs.
interface pc_sequencer_if;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        stall_req;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if_id;
  logic [1:0]  redirect_src;
  logic [1:0]  state;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] redirect_count;
  logic [15:0] stall_cycles;
`endif

  modport master (
    output jr_en, jr_target, jump_en, jump_target, branch_en, branch_target,
    output stall_req, halt,
    input  pc, pc_plus4, fetch_valid, flush_if_id, redirect_src, state
`ifdef PC_SEQ_STATS_EN
    , input redirect_count, stall_cycles
`endif
  );

  modport slave (
    input  jr_en, jr_target, jump_en, jump_target, branch_en, branch_target,
    input  stall_req, halt,
    output pc, pc_plus4, fetch_valid, flush_if_id, redirect_src, state
`ifdef PC_SEQ_STATS_EN
    , output redirect_count, stall_cycles
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencing for the fetch stage: boot delay, prioritised
// redirects, stalls, IF/ID flush window and sticky halt. PC_SEQ_STATS_EN adds counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StFlush = 2'd3
  } state_e;

  localparam logic [3:0] BootInit  = 4'(BOOT_CYCLES);
  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic [1:0]  src_q, src_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        halted_q, halted_d;

  logic        any_req;
  logic [31:0] target;
  logic [1:0]  target_src;

  assign any_req = bus.jr_en | bus.jump_en | bus.branch_en;

  always_comb begin
    target     = bus.branch_target;
    target_src = 2'd1;
    if (bus.jr_en) begin
      target     = bus.jr_target;
      target_src = 2'd3;
    end else if (bus.jump_en) begin
      target     = bus.jump_target;
      target_src = 2'd2;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    src_d         = src_q;
    boot_cnt_d    = boot_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    halted_d      = halted_q;
    if (state_q == StBoot) begin
      boot_cnt_d = boot_cnt_q - 4'd1;
      if (boot_cnt_q == 4'd1) begin
        state_d       = StRun;
        fetch_valid_d = 1'b1;
      end
    end else if (!halted_q) begin
      if (bus.halt) begin
        halted_d      = 1'b1;
        fetch_valid_d = 1'b0;
      end else if (state_q == StFlush) begin
        // Redirect requests here come from squashed instructions.
        flush_cnt_d = flush_cnt_q - 3'd1;
        src_d       = 2'd0;
        if (!bus.stall_req) pc_d = pc_q + 32'd4;
        if (flush_cnt_q == 3'd1) begin
          flush_d = 1'b0;
          state_d = StRun;
        end
      end else if (any_req) begin
        pc_d        = {target[31:2], 2'b00};
        src_d       = target_src;
        state_d     = StFlush;
        flush_d     = 1'b1;
        flush_cnt_d = FlushInit;
      end else if (bus.stall_req) begin
        state_d = StStall;
        src_d   = 2'd0;
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = StRun;
        src_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      src_q         <= 2'd0;
      boot_cnt_q    <= BootInit;
      flush_cnt_q   <= 3'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      src_q         <= src_d;
      boot_cnt_q    <= boot_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_q + 32'd4;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.flush_if_id  = flush_q;
  assign bus.redirect_src = src_q;
  assign bus.state        = state_q;

`ifdef PC_SEQ_STATS_EN
  logic        live, take_redirect, stall_hold;
  logic [15:0] redirect_count_q, stall_cycles_q;

  assign live          = (state_q != StBoot) && !halted_q && !bus.halt;
  assign take_redirect = live && (state_q != StFlush) && any_req;
  assign stall_hold    = live && bus.stall_req && !take_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count_q <= 16'd0;
      stall_cycles_q   <= 16'd0;
    end else begin
      if (take_redirect && redirect_count_q != 16'hFFFF) begin
        redirect_count_q <= redirect_count_q + 16'd1;
      end
      if (stall_hold && stall_cycles_q != 16'hFFFF) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign bus.redirect_count = redirect_count_q;
  assign bus.stall_cycles   = stall_cycles_q;
`endif

endmodule
